// File: rtl/alerta_actuador.sv
// Alert bus consumer: filters the 2-bit alert level, runs the severity FSM and drives alarm/fan.
// Optional event counter output enabled by defining CONTADOR_EVENTOS_EN.
module alerta_actuador #(
  parameter int unsigned FILTRO_CICLOS = 16,
  parameter int unsigned T_PARPADEO    = 25000000,
  parameter int unsigned T_ENFRIAR     = 250000000,
  parameter int unsigned ANCHO_CNT     = 28
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Alerta,
  input  logic       silenciar,
  output logic       Alarma,
  output logic       Ventilador,
  output logic [1:0] Estado
`ifdef CONTADOR_EVENTOS_EN
  ,
  output logic [7:0] eventos
`endif
);

  typedef enum logic [1:0] {
    StNormal       = 2'b00,
    StAviso        = 2'b01,
    StFuerte       = 2'b10,
    StEnfriamiento = 2'b11
  } estado_e;

  localparam logic [7:0]           FiltroMax = 8'(FILTRO_CICLOS);
  localparam logic [ANCHO_CNT-1:0] ParpMax   = ANCHO_CNT'(T_PARPADEO - 1);
  localparam logic [ANCHO_CNT-1:0] EnfrMax   = ANCHO_CNT'(T_ENFRIAR - 1);

  // Illegal code 01 decodes to the strongest level (fail-safe).
  function automatic logic [1:0] decodificar(input logic [1:0] a);
    case (a)
      2'b00:   return 2'd0;
      2'b10:   return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  estado_e              estado_q, estado_d;
  logic [1:0]           muestra_q, muestra_d;
  logic [1:0]           nivel_q, nivel_d;
  logic [7:0]           filtro_cnt_q, filtro_cnt_d;
  logic [ANCHO_CNT-1:0] parp_q, parp_d;
  logic                 fase_q, fase_d;
  logic [ANCHO_CNT-1:0] enfr_q, enfr_d;
  logic                 mudo_q, mudo_d;
  logic                 alarma_q, alarma_d;
  logic                 ventilador_q, ventilador_d;

  // Input filter: level accepted once the sample has been stable for FILTRO_CICLOS edges.
  always_comb begin
    muestra_d    = decodificar(Alerta);
    nivel_d      = nivel_q;
    filtro_cnt_d = '0;
    if (muestra_d == muestra_q) begin
      filtro_cnt_d = (filtro_cnt_q < FiltroMax) ? filtro_cnt_q + 8'd1 : filtro_cnt_q;
    end
    if (filtro_cnt_d == FiltroMax) begin
      nivel_d = muestra_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    enfr_d   = '0;
    unique case (estado_q)
      StNormal: begin
        if (nivel_q == 2'd2)      estado_d = StFuerte;
        else if (nivel_q == 2'd1) estado_d = StAviso;
      end
      StAviso: begin
        if (nivel_q == 2'd2)      estado_d = StFuerte;
        else if (nivel_q == 2'd0) estado_d = StNormal;
      end
      StFuerte: begin
        if (nivel_q != 2'd2) estado_d = StEnfriamiento;
      end
      StEnfriamiento: begin
        // Re-escalation beats cool-down expiry.
        if (nivel_q == 2'd2) begin
          estado_d = StFuerte;
        end else if (enfr_q == EnfrMax) begin
          estado_d = (nivel_q == 2'd1) ? StAviso : StNormal;
        end else begin
          enfr_d = enfr_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    parp_d = '0;
    fase_d = 1'b1;
    if (estado_q == StAviso && estado_d == StAviso) begin
      if (parp_q == ParpMax) begin
        parp_d = '0;
        fase_d = ~fase_q;
      end else begin
        parp_d = parp_q + 1'b1;
        fase_d = fase_q;
      end
    end

    mudo_d = mudo_q;
    if (silenciar && (estado_q == StAviso || estado_q == StFuerte)) begin
      mudo_d = 1'b1;
    end
    if (estado_d == StNormal || (estado_d == StFuerte && estado_q != StFuerte)) begin
      mudo_d = 1'b0;
    end

    ventilador_d = (estado_d == StFuerte) || (estado_d == StEnfriamiento);
    alarma_d     = !mudo_d && ((estado_d == StFuerte) || (estado_d == StAviso && fase_d));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      estado_q     <= StNormal;
      muestra_q    <= '0;
      nivel_q      <= '0;
      filtro_cnt_q <= '0;
      parp_q       <= '0;
      fase_q       <= 1'b1;
      enfr_q       <= '0;
      mudo_q       <= 1'b0;
      alarma_q     <= 1'b0;
      ventilador_q <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      muestra_q    <= muestra_d;
      nivel_q      <= nivel_d;
      filtro_cnt_q <= filtro_cnt_d;
      parp_q       <= parp_d;
      fase_q       <= fase_d;
      enfr_q       <= enfr_d;
      mudo_q       <= mudo_d;
      alarma_q     <= alarma_d;
      ventilador_q <= ventilador_d;
    end
  end

  assign Estado     = estado_q;
  assign Alarma     = alarma_q;
  assign Ventilador = ventilador_q;

`ifdef CONTADOR_EVENTOS_EN
  logic [7:0] eventos_q, eventos_d;

  always_comb begin
    eventos_d = eventos_q;
    if (estado_d == StFuerte && estado_q != StFuerte && eventos_q != 8'hFF) begin
      eventos_d = eventos_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) eventos_q <= '0;
    else        eventos_q <= eventos_d;
  end

  assign eventos = eventos_q;
`endif

endmodule

// File: tb/tb_alerta_actuador.sv
// Randomized bench for alerta_actuador, checked every cycle against a behavioural model.
module tb_alerta_actuador;

  localparam int F  = 4;
  localparam int TP = 3;
  localparam int TE = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] Alerta = 2'b00;
  logic       silenciar = 1'b0;
  logic       Alarma;
  logic       Ventilador;
  logic [1:0] Estado;
`ifdef CONTADOR_EVENTOS_EN
  logic [7:0] eventos;
`endif

  int errores = 0;
  int checks  = 0;

  // Model: state 0..3 as Estado codes, filter as a window of recent samples,
  // blink phase from time spent in AVISO.
  int m_st, m_filt, m_mute, m_tav, m_enf, m_ev;
  int q[$];

  alerta_actuador #(
    .FILTRO_CICLOS(F),
    .T_PARPADEO   (TP),
    .T_ENFRIAR    (TE),
    .ANCHO_CNT    (28)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Alerta    (Alerta),
    .silenciar (silenciar),
    .Alarma    (Alarma),
    .Ventilador(Ventilador),
    .Estado    (Estado)
`ifdef CONTADOR_EVENTOS_EN
    ,
    .eventos   (eventos)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errores++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int decod(input logic [1:0] a);
    if (a == 2'b00) return 0;
    if (a == 2'b10) return 1;
    return 2;
  endfunction

  task automatic model_edge();
    int  ns;
    int  lvl;
    bit  igual;
    if (!reset) begin
      m_st = 0; m_filt = 0; m_mute = 0; m_tav = 0; m_enf = 0; m_ev = 0;
      q.delete();
      q.push_back(0);
    end else begin
      lvl = m_filt;
      ns  = m_st;
      case (m_st)
        0: if (lvl == 2) ns = 2; else if (lvl == 1) ns = 1;
        1: if (lvl == 2) ns = 2; else if (lvl == 0) ns = 0;
        2: if (lvl < 2) ns = 3;
        default: begin
          if (lvl == 2) ns = 2;
          else if (m_enf == TE - 1) ns = (lvl == 1) ? 1 : 0;
        end
      endcase
      m_enf = (ns == 3 && m_st == 3) ? m_enf + 1 : 0;
      if (silenciar && (m_st == 1 || m_st == 2)) m_mute = 1;
      if (ns == 0 || (ns == 2 && m_st != 2)) m_mute = 0;
      m_tav = (ns == 1 && m_st == 1) ? m_tav + 1 : 0;
      if (ns == 2 && m_st != 2 && m_ev < 255) m_ev++;
      m_st = ns;
      q.push_back(decod(Alerta));
      if (q.size() > F + 1) void'(q.pop_front());
      if (q.size() == F + 1) begin
        igual = 1'b1;
        foreach (q[j]) if (q[j] != q[0]) igual = 1'b0;
        if (igual) m_filt = q[0];
      end
    end
  endtask

  task automatic paso();
    int exp_alarma;
    @(posedge clk);
    model_edge();
    #1;
    exp_alarma = (m_mute == 0) && (m_st == 2 || (m_st == 1 && ((m_tav / TP) % 2 == 0)));
    check("estado", 32'(Estado), m_st);
    check("ventilador", 32'(Ventilador), (m_st >= 2) ? 1 : 0);
    check("alarma", 32'(Alarma), exp_alarma);
`ifdef CONTADOR_EVENTOS_EN
    check("eventos", 32'(eventos), m_ev);
`endif
  endtask

  task automatic mantener(input logic [1:0] a, input int n);
    Alerta = a;
    repeat (n) paso();
  endtask

  task automatic pulso_silenciar();
    silenciar = 1'b1;
    paso();
    silenciar = 1'b0;
  endtask

  initial begin
    int r;
    int len;
    reset  = 1'b0;
    Alerta = 2'b11;
    repeat (3) paso();
    reset = 1'b1;
    mantener(2'b11, 12);
    mantener(2'b00, 25);
    mantener(2'b10, 20);
    mantener(2'b00, 10);
    mantener(2'b10, 3);
    mantener(2'b00, 10);
    // Re-escalation partway through cool-down.
    mantener(2'b11, 10);
    mantener(2'b00, 10);
    mantener(2'b11, 10);
    mantener(2'b00, 25);
    // Mute in AVISO, then escalation clears it.
    mantener(2'b10, 12);
    pulso_silenciar();
    mantener(2'b10, 8);
    mantener(2'b11, 10);
    mantener(2'b00, 25);
    // Mute pulse on the same edge as AVISO->FUERTE.
    mantener(2'b10, 15);
    mantener(2'b11, 5);
    pulso_silenciar();
    mantener(2'b11, 4);
    // Mute in FUERTE persists through cool-down into AVISO.
    pulso_silenciar();
    mantener(2'b10, 25);
    mantener(2'b00, 10);
    // Illegal code and reset during cool-down.
    mantener(2'b01, 10);
    mantener(2'b00, 8);
    reset = 1'b0;
    paso();
    reset = 1'b1;
    mantener(2'b00, 10);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      Alerta = (r < 3) ? 2'b00 : (r < 6) ? 2'b10 : (r < 9) ? 2'b11 : 2'b01;
      len = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 7) : $urandom_range(8, 30);
      for (int c = 0; c < len; c++) begin
        silenciar = ($urandom_range(0, 7) == 0);
        reset     = ($urandom_range(0, 199) != 0);
        paso();
      end
    end
    silenciar = 1'b0;
    reset     = 1'b1;

    $display("Result: errors=%0d of %0d checks", errores, checks);
    $finish;
  end

endmodule
